// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT widths, constants, state types and the bit-reverse helper
package fft_pkg;

    localparam int REAL_WIDTH_DEF = 18;
    localparam int IMGN_WIDTH_DEF = 18;
    localparam int CPLX_WIDTH     = REAL_WIDTH_DEF + IMGN_WIDTH_DEF;

    // Idle output address; users truncate to their stage count, giving all-ones
    localparam logic [31:0] IDLE_ADDR = '1;

    typedef enum logic {
        RD_IDLE,
        RD_READ
    } rd_state_t;

    function automatic int cplx_width(input int rw, input int iw);
        return rw + iw;
    endfunction

    // Mirror the low w bits of a: bit i lands on bit w-1-i
    function automatic logic [31:0] bitrev(input logic [31:0] a, input int w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r[w-1-i] = a[i];
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// fft_reorder_ram: simple dual-port RAM, one write port and one registered read port
module fft_reorder_ram #(
    parameter int AW = 12,
    parameter int DW = 36
) (
    input  logic          iclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Write port plus one-cycle synchronous read; contents are never reset
    always_ff @(posedge iclk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fft_reorder.sv
// fft_reorder: ping-pong buffer turning bit-reversed FFT output into natural bin order
module fft_reorder
    import fft_pkg::*;
#(
    parameter int TOTAL_STAGE = 11,
    parameter int REAL_WIDTH  = 18,
    parameter int IMGN_WIDTH  = 18
) (
    input  logic                                            iclk,
    input  logic                                            rst,
    input  logic                                            ien,
    input  logic [TOTAL_STAGE-1:0]                          iaddr,
    input  logic [cplx_width(REAL_WIDTH, IMGN_WIDTH)-1:0]   idata,
    output logic                                            oen,
    output logic [TOTAL_STAGE-1:0]                          oaddr,
    output logic [cplx_width(REAL_WIDTH, IMGN_WIDTH)-1:0]   odata,
    output logic                                            osop,
    output logic                                            oeop,
    output logic                                            ovf
);

    localparam int CW = cplx_width(REAL_WIDTH, IMGN_WIDTH);
    localparam logic [TOTAL_STAGE-1:0] LAST   = '1;
    localparam logic [TOTAL_STAGE-1:0] IDLE_A = TOTAL_STAGE'(IDLE_ADDR);

    rd_state_t              state, state_n;
    logic [1:0]             full, full_eff, wset, rclr;
    logic                   wb, rb, acc;
    logic                   sof, eof, accept, drop, we, re;
    logic [TOTAL_STAGE-1:0] cnt, wa;
    logic                   v1, sop1, eop1;
    logic [TOTAL_STAGE-1:0] a1;
    logic [CW-1:0]          rdata;

    // Frame start/end and the bank a completed frame marks full
    assign sof  = ien && iaddr == '0;
    assign eof  = ien && acc && iaddr == LAST;
    assign wset = eof ? (2'b01 << wb) : 2'b00;
    assign wa   = TOTAL_STAGE'(bitrev(32'(iaddr), TOTAL_STAGE));

    // Reader: IDLE issues address 0 as soon as its bank fills; READ streams with no stall
    always_comb begin
        state_n = state;
        re      = 1'b0;
        rclr    = 2'b00;
        if (state == RD_IDLE) begin
            if (full[rb]) begin
                re      = 1'b1;
                state_n = RD_READ;
            end
        end else begin
            re = 1'b1;
            if (cnt == LAST) begin
                rclr    = 2'b01 << rb;
                state_n = (full[!rb] || wset[!rb]) ? RD_READ : RD_IDLE;
            end
        end
    end

    // Writer accept check sees the reader's same-cycle clear, so a freed bank is accepted
    always_comb begin
        full_eff = full & ~rclr;
        accept   = sof && !full_eff[wb];
        drop     = sof && full_eff[wb];
        we       = accept || (ien && acc && !sof);
    end

    // Bank flags, pointers, writer sync and reader counter
    always_ff @(posedge iclk) begin
        if (rst) begin
            state <= RD_IDLE;
            cnt   <= '0;
            full  <= '0;
            wb    <= 1'b0;
            rb    <= 1'b0;
            acc   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= re ? cnt + 1'b1 : cnt;
            full  <= full_eff | wset;
            wb    <= wb ^ (|wset);
            rb    <= rb ^ (|rclr);
            acc   <= sof ? accept : (eof ? 1'b0 : acc);
            ovf   <= drop;
        end
    end

    // Two-stage output pipeline matching the RAM read latency, idle values when not valid
    always_ff @(posedge iclk) begin
        if (rst) begin
            v1    <= 1'b0;
            a1    <= '0;
            sop1  <= 1'b0;
            eop1  <= 1'b0;
            oen   <= 1'b0;
            oaddr <= IDLE_A;
            odata <= '0;
            osop  <= 1'b0;
            oeop  <= 1'b0;
        end else begin
            v1    <= re;
            a1    <= cnt;
            sop1  <= cnt == '0;
            eop1  <= cnt == LAST;
            oen   <= v1;
            oaddr <= v1 ? a1 : IDLE_A;
            odata <= v1 ? rdata : '0;
            osop  <= v1 && sop1;
            oeop  <= v1 && eop1;
        end
    end

    fft_reorder_ram #(
        .AW(TOTAL_STAGE + 1),
        .DW(CW)
    ) u_ram (
        .iclk (iclk),
        .we   (we),
        .waddr({wb, wa}),
        .wdata(idata),
        .re   (re),
        .raddr({rb, cnt}),
        .rdata(rdata)
    );

endmodule
